axi_burst_write_engine: RTL and testbench

Copies a contiguous block of words from a local synchronous-read buffer to AXI4 memory using INCR write bursts. It has a valid/ready start/done command interface and is an AXI4 write-only master. Bursts are split at AXIMaxBurstLen beats and at 4 KB boundaries, with one outstanding write burst at a time. It sits between a kernel-side data buffer and an AXI memory port.

---
 rtl/axi_bw_pkg.sv | 16 +
 rtl/axi_bw_prefetch_fifo.sv | 43 ++++
 rtl/axi_burst_write_engine.sv | 193 +++++++++++++++++++
 tb/tb_axi_burst_write_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bw_pkg.sv
// Shared constants and state encoding for the AXI burst write engine.
package axi_bw_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4KB        = 4096;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    DONE
  } state_e;

endpackage

// File: rtl/axi_bw_prefetch_fifo.sv
// Two-entry FIFO holding buffer words between the read port and the W channel.
module axi_bw_prefetch_fifo #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // Storage needs no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_q ^ push_i;
      rd_ptr_q <= rd_ptr_q ^ pop_i;
      count_q  <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/axi_burst_write_engine.sv
// Copies a block of buffer words to AXI4 memory as INCR bursts, split at the
// maximum burst length and at 4 KB boundaries, one burst in flight at a time.
module axi_burst_write_engine
  import axi_bw_pkg::*;
#(
  parameter int BufferDataWidth = 32,
  parameter int BufferAddrWidth = 8,
  parameter int AXIAddrWidth    = 32,
  parameter int AXIDataWidth    = 32,
  parameter int AXIMaxBurstLen  = 16,
  parameter int AXIIDWidth      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_valid,
  output logic                       start_ready,
  output logic                       done_valid,
  input  logic                       done_ready,
  input  logic [BufferAddrWidth-1:0] data_ptr,
  input  logic [BufferAddrWidth-1:0] data_size,
  input  logic [AXIAddrWidth-1:0]    axi_offset,
  output logic [BufferAddrWidth-1:0] buffer_addr,
  input  logic [BufferDataWidth-1:0] buffer_data,
  output logic                       buffer_ce,
  output logic                       buffer_we,
  output logic [AXIAddrWidth-1:0]    awaddr,
  output logic [AXIIDWidth-1:0]      awid,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [AXIDataWidth-1:0]    wdata,
  output logic [AXIDataWidth/8-1:0]  wstrb,
  output logic [AXIIDWidth-1:0]      wid,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [AXIIDWidth-1:0]      bid,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);

  localparam int BYTES     = AXIDataWidth / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);
  localparam int CW        = ((BufferAddrWidth > 13) ? BufferAddrWidth : 13) + 1;

  state_e                     state_q, state_d;
  logic [AXIAddrWidth-1:0]    addr_q, addr_d;
  logic [BufferAddrWidth-1:0] ptr_q, ptr_d;
  logic [BufferAddrWidth-1:0] remaining_q, remaining_d;
  logic [8:0]                 rd_cnt_q, rd_cnt_d;
  logic [8:0]                 wr_cnt_q, wr_cnt_d;
  logic                       inflight_q, inflight_d;

  logic [CW-1:0]              rem_ext, max_ext, bnd_ext, beats_w;
  logic [8:0]                 beats9;
  logic [BufferDataWidth-1:0] fifo_head;
  logic                       fifo_empty;
  logic [1:0]                 fifo_count;
  logic                       pop_w;
  logic [2:0]                 occ_w;
  logic                       last_beat;
  logic                       unused_bresp;

  assign unused_bresp = ^{bid, bresp, AXI_RESP_OKAY};

  // Beats in the current burst: limited by what is left, the burst cap, and
  // the distance to the next 4 KB page.
  assign rem_ext = CW'(remaining_q);
  assign max_ext = CW'(AXIMaxBurstLen);
  assign bnd_ext = CW'((13'(AXI_4KB) - {1'b0, addr_q[11:0]}) >> SIZE_LOG2);

  always_comb begin
    beats_w = rem_ext;
    if (max_ext < beats_w) beats_w = max_ext;
    if (bnd_ext < beats_w) beats_w = bnd_ext;
  end

  assign beats9    = beats_w[8:0];
  assign last_beat = (wr_cnt_q == beats9 - 9'd1);
  assign pop_w     = (state_q == DATA) && !fifo_empty && wready;
  // Words held or already requested, after this cycle's W handshake.
  assign occ_w     = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop_w};

  assign awaddr      = addr_q;
  assign awid        = '0;
  assign awlen       = 8'(beats_w - CW'(1));
  assign awsize      = 3'(SIZE_LOG2);
  assign awburst     = AXI_BURST_INCR;
  assign wdata       = fifo_head;
  assign wstrb       = '1;
  assign wid         = '0;
  assign wlast       = (state_q == DATA) && !fifo_empty && last_beat;
  assign buffer_we   = 1'b0;
  assign buffer_addr = ptr_q + BufferAddrWidth'(rd_cnt_q);

  axi_bw_prefetch_fifo #(
    .Width(BufferDataWidth)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (inflight_q),
    .push_data_i(buffer_data),
    .pop_i      (pop_w),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    inflight_d  = 1'b0;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    buffer_ce   = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          ptr_d       = data_ptr;
          remaining_d = data_size;
          addr_d      = axi_offset;
          state_d     = (data_size == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        awvalid = 1'b1;
        if (awready) begin
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        wvalid    = !fifo_empty;
        buffer_ce = (rd_cnt_q != beats9) && (occ_w < 3'd2);
        if (buffer_ce) begin
          rd_cnt_d   = rd_cnt_q + 9'd1;
          inflight_d = 1'b1;
        end
        if (pop_w) begin
          wr_cnt_d = wr_cnt_q + 9'd1;
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          addr_d      = addr_q + (AXIAddrWidth'(beats_w) << SIZE_LOG2);
          ptr_d       = ptr_q + BufferAddrWidth'(beats_w);
          remaining_d = remaining_q - BufferAddrWidth'(beats_w);
          state_d     = (remaining_q == BufferAddrWidth'(beats_w)) ? DONE : ADDR;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_write_engine.sv
// Directed bench: buffer model, AXI write slave with optional stalls, and
// hand-computed burst/data expectations for each transfer.
module tb_axi_burst_write_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid, start_ready, done_valid, done_ready;
  logic [7:0]  data_ptr, data_size, buffer_addr;
  logic [31:0] axi_offset, buffer_data, awaddr, wdata;
  logic        buffer_ce, buffer_we;
  logic [0:0]  awid, wid, bid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi_burst_write_engine dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .done_valid(done_valid), .done_ready(done_ready),
    .data_ptr(data_ptr), .data_size(data_size), .axi_offset(axi_offset),
    .buffer_addr(buffer_addr), .buffer_data(buffer_data),
    .buffer_ce(buffer_ce), .buffer_we(buffer_we),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Buffer model: registered read, one cycle after a ce-qualified address.
  logic [31:0] bufmem [256];
  always @(posedge clk) if (buffer_ce) buffer_data <= bufmem[buffer_addr];

  logic [31:0] mem [2048];

  // AXI slave state
  int          aw_cnt, outstanding, beat, cur_len, st_aw, st_w, st_b;
  logic [31:0] aw_addr_log [8];
  logic [7:0]  aw_len_log [8];
  logic [31:0] cur_addr, prev_wdata;
  logic        prev_wlast, prev_stall, pending_b, b_fired, stall_en, go;

  task automatic next_ready(input int cnt_in, output int cnt_out, output logic rdy);
    if (cnt_in > 0) begin
      cnt_out = cnt_in - 1; rdy = 1'b0;
    end else if ($urandom_range(0, 99) < 30) begin
      cnt_out = int'($urandom_range(1, 5)) - 1; rdy = 1'b0;
    end else begin
      cnt_out = 0; rdy = 1'b1;
    end
  endtask

  initial begin
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bid = '0; bresp = 2'b00;
    aw_cnt = 0; outstanding = 0; beat = 0; cur_len = 0; cur_addr = 0;
    st_aw = 0; st_w = 0; st_b = 0; prev_stall = 0; pending_b = 0; b_fired = 0;
    prev_wdata = 0; prev_wlast = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        outstanding = 0; beat = 0; pending_b = 0; b_fired = 0; prev_stall = 0;
        bvalid = 1'b0; awready = 1'b1; wready = 1'b1;
        continue;
      end
      if (b_fired) begin bvalid = 1'b0; b_fired = 1'b0; end
      if (stall_en) begin
        next_ready(st_aw, st_aw, awready);
        next_ready(st_w, st_w, wready);
      end else begin
        awready = 1'b1; wready = 1'b1;
      end
      if (pending_b && !bvalid) begin
        go = 1'b1;
        if (stall_en) next_ready(st_b, st_b, go);
        if (go) begin bvalid = 1'b1; pending_b = 1'b0; end
      end
      #1;
      if (prev_stall) begin
        chk("w_stall_valid", wvalid, 1);
        chk("w_stall_data", wdata, prev_wdata);
        chk("w_stall_last", wlast, prev_wlast);
      end
      prev_stall = wvalid && !wready;
      prev_wdata = wdata;
      prev_wlast = wlast;
      if (awvalid && awready) begin
        chk("one_outstanding", outstanding, 0);
        if (aw_cnt < 8) begin
          aw_addr_log[aw_cnt] = awaddr;
          aw_len_log[aw_cnt]  = awlen;
        end
        aw_cnt++;
        outstanding = 1; beat = 0; cur_addr = awaddr; cur_len = awlen;
      end
      if (wvalid && wready) begin
        mem[(cur_addr >> 2) + beat] = wdata;
        chk($sformatf("wlast_b%0d", beat), wlast, (beat == cur_len));
        if (beat == cur_len) pending_b = 1'b1;
        beat++;
      end
      if (bvalid && bready) begin
        outstanding = 0; b_fired = 1'b1;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 32'hDEADBEEF;
    aw_cnt = 0;
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] ptr, input logic [7:0] size,
                          input logic [31:0] off);
    logic got;
    clear_mem();
    @(negedge clk);
    data_ptr = ptr; data_size = size; axi_offset = off; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    data_ptr = 8'hFF; data_size = 8'h77; axi_offset = 32'hFFFF_0000;
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_done"}, got, 1);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    chk({tag, "_idle"}, start_ready, 1);
    chk({tag, "_done_drop"}, done_valid, 0);
  endtask

  task automatic chk_aw(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
    chk($sformatf("%s_aw%0d_addr", tag, idx), aw_addr_log[idx], a);
    chk($sformatf("%s_aw%0d_len", tag, idx), aw_len_log[idx], l);
  endtask

  task automatic chk_mem(input string tag, input int word0, input int ptr, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_mem%0d", tag, i), mem[word0 + i], bufmem[(ptr + i) & 255]);
    chk({tag, "_mem_after"}, mem[word0 + n], 32'hDEADBEEF);
    if (word0 > 0) chk({tag, "_mem_before"}, mem[word0 - 1], 32'hDEADBEEF);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 256; i++) bufmem[i] = 32'hB000_0000 + (i * 32'h0001_0003);
    stall_en = 1'b0;
    reset = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    data_ptr = '0; data_size = '0; axi_offset = '0;
    #12;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_buffer_ce", buffer_ce, 0);
    chk("const_awsize", awsize, 3'd2);
    chk("const_awburst", awburst, 2'b01);
    chk("const_wstrb", wstrb, 4'hF);
    chk("const_ids", {awid, wid}, 2'b00);
    chk("const_buffer_we", buffer_we, 0);
    @(negedge clk);
    reset = 1'b0;

    run_xfer("single", 8'd0, 8'd1, 32'h0);
    chk("single_aw_cnt", aw_cnt, 1);
    chk_aw("single", 0, 32'h0, 8'd0);
    chk_mem("single", 0, 0, 1);

    run_xfer("split", 8'd0, 8'd32, 32'h0);
    chk("split_aw_cnt", aw_cnt, 2);
    chk_aw("split", 0, 32'h000, 8'd15);
    chk_aw("split", 1, 32'h040, 8'd15);
    chk_mem("split", 0, 0, 32);

    run_xfer("rem", 8'd5, 8'd17, 32'h100);
    chk("rem_aw_cnt", aw_cnt, 2);
    chk_aw("rem", 0, 32'h100, 8'd15);
    chk_aw("rem", 1, 32'h140, 8'd0);
    chk_mem("rem", 32'h40, 5, 17);

    run_xfer("4k", 8'd0, 8'd4, 32'hFF8);
    chk("4k_aw_cnt", aw_cnt, 2);
    chk_aw("4k", 0, 32'hFF8, 8'd1);
    chk_aw("4k", 1, 32'h1000, 8'd1);
    chk_mem("4k", 32'h3FE, 0, 4);

    run_xfer("wrap", 8'd250, 8'd10, 32'h800);
    chk("wrap_aw_cnt", aw_cnt, 1);
    chk_aw("wrap", 0, 32'h800, 8'd9);
    chk_mem("wrap", 32'h200, 250, 10);

    stall_en = 1'b1; bresp = 2'b10;
    run_xfer("stall", 8'd100, 8'd40, 32'h400);
    stall_en = 1'b0; bresp = 2'b00;
    chk("stall_aw_cnt", aw_cnt, 3);
    chk_aw("stall", 0, 32'h400, 8'd15);
    chk_aw("stall", 1, 32'h440, 8'd15);
    chk_aw("stall", 2, 32'h480, 8'd7);
    chk_mem("stall", 32'h100, 100, 40);

    run_xfer("zero", 8'd3, 8'd0, 32'h200);
    chk("zero_aw_cnt", aw_cnt, 0);

    // Reset in the middle of a streaming burst
    clear_mem();
    @(negedge clk);
    data_ptr = 8'd0; data_size = 8'd40; axi_offset = 32'h0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (wvalid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("midrst_streaming", seen && wvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_awvalid", awvalid, 0);
    chk("midrst_wvalid", wvalid, 0);
    chk("midrst_wlast", wlast, 0);
    chk("midrst_bready", bready, 0);
    chk("midrst_buffer_ce", buffer_ce, 0);
    chk("midrst_done_valid", done_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_start_ready", start_ready, 1);

    run_xfer("after_rst", 8'd7, 8'd3, 32'h20);
    chk("after_rst_aw_cnt", aw_cnt, 1);
    chk_aw("after_rst", 0, 32'h20, 8'd2);
    chk_mem("after_rst", 8, 7, 3);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
